// File: rtl/johnson_phase_tracker.sv
// Johnson ring phase tracker: validates and decodes ring samples,
// checks single-step advance, locks, counts revolutions, flags errors.
module johnson_phase_tracker #(
  parameter int WIDTH      = 6,
  parameter int PW         = 4,
  parameter int LOCK_COUNT = 3,
  parameter int REV_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic                   en,
  input  logic [WIDTH-1:0]       code,
  input  logic                   err_clr,
  output logic [PW-1:0]          phase,
  output logic                   phase_valid,
  output logic [2*WIDTH-1:0]     phase_onehot,
  output logic                   locked,
  output logic                   step_err,
  output logic                   err_sticky,
  output logic [REV_WIDTH-1:0]   rev_count,
  output logic                   rev_tick
);

  localparam int L  = 2 * WIDTH;
  localparam int RW = $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    SEEK,
    TRACK,
    LOCKED
  } state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          run_q, run_d;
  logic [PW-1:0]          phase_d;
  logic                   valid_d;
  logic [L-1:0]           oh_d;
  logic                   serr_d;
  logic                   sticky_d;
  logic [REV_WIDTH-1:0]   rev_d;
  logic                   tick_d;

  logic                   legal;
  logic [PW-1:0]          idx;
  logic [PW-1:0]          succ;
  logic                   is_succ;
  logic                   is_stall;
  logic [RW-1:0]          run_inc;
  logic [L-1:0]           idx_oh;

  function automatic logic [WIDTH-1:0] pat(input int k);
    logic [WIDTH-1:0] ones;
    ones = '1;
    if (k <= WIDTH) pat = ones >> (WIDTH - k);
    else            pat = ones << (k - WIDTH);
  endfunction

  always_comb begin
    legal = 1'b0;
    idx   = '0;
    for (int k = 0; k < L; k++) begin
      if (code == pat(k)) begin
        legal = 1'b1;
        idx   = PW'(k);
      end
    end
  end

  // phase register doubles as the previous legal index
  assign succ     = (phase == PW'(L - 1)) ? '0 : phase + 1'b1;
  assign is_succ  = (idx == succ);
  assign is_stall = (idx == phase);
  assign run_inc  = run_q + 1'b1;
  assign idx_oh   = {{(L-1){1'b0}}, 1'b1} << idx;

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    phase_d  = phase;
    valid_d  = phase_valid;
    oh_d     = phase_onehot;
    serr_d   = 1'b0;
    tick_d   = 1'b0;
    rev_d    = rev_count;
    if (en) begin
      valid_d = legal;
      oh_d    = legal ? idx_oh : '0;
      if (legal) phase_d = idx;
      unique case (state_q)
        SEEK: begin
          if (legal) begin
            state_d = TRACK;
            run_d   = RW'(1);
          end
        end
        TRACK: begin
          if (!legal) begin
            state_d = SEEK;
            run_d   = '0;
          end else if (is_succ) begin
            run_d = run_inc;
            if (run_inc == RW'(LOCK_COUNT)) state_d = LOCKED;
          end else if (!is_stall) begin
            run_d = RW'(1);
          end
        end
        LOCKED: begin
          if (!legal) begin
            serr_d  = 1'b1;
            state_d = SEEK;
            run_d   = '0;
          end else if (is_succ) begin
            if (phase == PW'(L - 1)) begin
              tick_d = 1'b1;
              rev_d  = rev_count + 1'b1;
            end
          end else if (!is_stall) begin
            serr_d  = 1'b1;
            state_d = TRACK;
            run_d   = RW'(1);
          end
        end
        default: state_d = SEEK;
      endcase
    end
    // a new error outranks a simultaneous clear request
    sticky_d = serr_d ? 1'b1 : (err_clr ? 1'b0 : err_sticky);
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q      <= SEEK;
      run_q        <= '0;
      phase        <= '0;
      phase_valid  <= 1'b0;
      phase_onehot <= '0;
      step_err     <= 1'b0;
      err_sticky   <= 1'b0;
      rev_count    <= '0;
      rev_tick     <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      phase        <= phase_d;
      phase_valid  <= valid_d;
      phase_onehot <= oh_d;
      step_err     <= serr_d;
      err_sticky   <= sticky_d;
      rev_count    <= rev_d;
      rev_tick     <= tick_d;
    end
  end

  assign locked = (state_q == LOCKED);

endmodule
